jk_bank_arbiter: RTL and testbench
==================================

# jk_bank_arbiter

Shares one WIDTH-bit bank of JK flip-flops between NREQ requesters. Each requester issues masked SET/CLEAR/TOGGLE/HOLD commands over a valid/ready handshake. A round-robin arbiter accepts at most one command per two cycles and converts it into per-bit J/K drive for the bank. The block is the control layer above the JK flip-flop primitive and exposes the bank state as q/qbar.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, number of JK flip-flops in the bank
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester command valid
- req_op  in  2*NREQ  per-requester op; requester i uses bits [2i+1:2i]
- req_mask  in  WIDTH*NREQ  per-requester bit mask; requester i uses bits [WIDTH*i +: WIDTH]
- req_ready  out  NREQ  one-hot grant, combinational
- q  out  WIDTH  bank state
- qbar  out  WIDTH  always ~q
- done  out  1  one-cycle pulse: the last accepted command is now visible on q
- done_id  out  clog2(NREQ) (min 1)  requester index of the completed command
- req_lock  in  NREQ  present only with JK_ARB_LOCK_EN

## Operation
- Op encoding:
  - 00 HOLD: j=0, k=0
  - 01 CLEAR: j=0, k=1
  - 10 SET: j=1, k=0
  - 11 TOGGLE: j=1, k=1
- Masked-off bits always get j=k=0 (hold).
- HOLD is still a legal command: it is accepted and produces done.
- FSM states:
  - IDLE: arbitrate; on handshake latch op, mask and id, then go to APPLY.
  - APPLY: drive j/k to the bank for exactly one cycle, then return to IDLE and assert done.
- req_ready[i] is 1 only in IDLE, only when req_valid[i]=1, and only for the round-robin winner. At most one bit is set.
- Round robin:
  - Search starts at rr_ptr+1 mod NREQ.
  - rr_ptr is loaded with the granted index on every handshake.
- Requesters must hold valid, op and mask stable until ready. The block never drops a valid request; a waiting requester is granted within NREQ accepts.
- Reset values: q=0, qbar=all ones, state=IDLE, done=0, done_id=0, rr_ptr=NREQ-1 (so requester 0 wins first).
- Reset asserted during APPLY: the command is discarded and no done pulse follows.
- A new accept may occur in the same IDLE cycle as done.

## Timing
- Cycle T: IDLE with req_valid[i]&&req_ready[i]; command is latched.
- Cycle T+1: APPLY; j/k drive the bank; q updates at the edge ending T+1.
- Cycle T+2: IDLE; q/qbar show the new value; done=1, done_id=i. The next handshake may happen at T+2.
- Latency from accept to visible q: 2 cycles. Peak throughput: 1 command per 2 cycles.
- No combinational path from req_* to q, done or done_id. The only combinational path is req_valid -> req_ready.

## Configuration
- JK_ARB_LOCK_EN defined:
  - The req_lock port exists.
  - A handshake with req_lock[i]=1 locks the arbiter to requester i; while locked, only i can be granted and rr_ptr is frozen.
  - The lock is released by a handshake from i with req_lock[i]=0, or by any IDLE cycle with req_valid[i]=0.
  - Reset clears the lock.
- JK_ARB_LOCK_EN undefined: the req_lock port is absent and arbitration is pure round robin.

## Structure
- Package jk_arb_pkg holds:
  - op encoding constants JK_OP_HOLD/CLEAR/SET/TOGGLE
  - the FSM state typedef (IDLE, APPLY)
  - a function mapping (op, mask) to the {j, k} vectors
- Sub-module jk_reg_bank: WIDTH JK flip-flops with ports clk, reset (sync, clears to q=0), j[WIDTH], k[WIDTH], q, qbar.
  - Standard JK truth table: 00 hold, 01 clear, 10 set, 11 toggle.
- The top level contains the arbiter, command register, FSM and done logic.

## Test plan
- Reset held 3 cycles, then released -> q=0x00, qbar=0xFF, done=0, req_ready=0 with no valid.
- Requester 0 sends SET mask=0x0F at T -> req_ready[0]=1 at T; at T+2 q=0x0F, done=1, done_id=0.
- All four requesters valid, each sending TOGGLE mask=0x01 -> grants in order 0,1,2,3 at T, T+2, T+4, T+6; final q[0] equals its start value; each grant's done_id matches.
- q=0xFF, requester 2 sends CLEAR mask=0xA5 -> q=0x5A at T+2; then HOLD mask=0xFF -> q stays 0x5A, done pulses.
- Reset asserted during APPLY of a SET mask=0xFF -> q=0x00, no done, state IDLE; rr_ptr=NREQ-1, so requester 0 wins next.
- With JK_ARB_LOCK_EN, requester 1 issues 3 locked commands while requester 0 is valid throughout -> requester 1 receives 3 consecutive grants; requester 0 is granted only after requester 1's unlocked handshake.

Source files
------------

// File: rtl/jk_bank_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// jk_arb_pkg
// Shared definitions for the jk_bank_arbiter block:
//   - JK_OP_* : 2-bit command encodings (HOLD/CLEAR/SET/TOGGLE)
//   - jk_state_t : arbiter FSM states (IDLE, APPLY)
//   - jk_drive   : maps (op, mask) to per-bit {j, k} drive
// The op encoding deliberately equals {j, k}, so SET=10 means j=1,k=0.
// ---------------------------------------------------------------------------
package jk_arb_pkg;

  localparam logic [1:0] JK_OP_HOLD   = 2'b00;
  localparam logic [1:0] JK_OP_CLEAR  = 2'b01;
  localparam logic [1:0] JK_OP_SET    = 2'b10;
  localparam logic [1:0] JK_OP_TOGGLE = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } jk_state_t;

  // {j, k} drive for one bank bit; masked-off bits always hold.
  function automatic logic [1:0] jk_drive(input logic [1:0] op, input logic mask);
    logic [1:0] jk;
    jk = 2'b00;
    if (mask) begin
      unique case (op)
        JK_OP_HOLD:   jk = 2'b00;
        JK_OP_CLEAR:  jk = 2'b01;
        JK_OP_SET:    jk = 2'b10;
        default:      jk = 2'b11;
      endcase
    end
    return jk;
  endfunction

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// ---------------------------------------------------------------------------
// jk_bank_arbiter_if
// Requester-side command bus for jk_bank_arbiter.
//   req_valid [NREQ]        : per-requester command valid
//   req_op    [2*NREQ]      : requester i op in [2i+1:2i]
//   req_mask  [WIDTH*NREQ]  : requester i mask in [WIDTH*i +: WIDTH]
//   req_ready [NREQ]        : one-hot grant from the arbiter
//   req_lock  [NREQ]        : only when JK_ARB_LOCK_EN is defined
// Modports: master (requesters), slave (arbiter).
// ---------------------------------------------------------------------------
interface jk_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) ();

  logic [NREQ-1:0]       req_valid;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_mask;
  logic [NREQ-1:0]       req_ready;
`ifdef JK_ARB_LOCK_EN
  logic [NREQ-1:0]       req_lock;

  modport master (
    output req_valid, req_op, req_mask, req_lock,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_mask, req_lock,
    output req_ready
  );
`else
  modport master (
    output req_valid, req_op, req_mask,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_mask,
    output req_ready
  );
`endif

endinterface

// File: rtl/jk_bank_arbiter_bank.sv
// ---------------------------------------------------------------------------
// jk_reg_bank
// WIDTH independent JK flip-flops with a synchronous active-high reset.
//   clk   : clock
//   reset : synchronous, clears q to 0
//   j, k  : per-bit JK inputs (00 hold, 01 clear, 10 set, 11 toggle)
//   q     : bank state
//   qbar  : ~q
// ---------------------------------------------------------------------------
module jk_reg_bank
  import jk_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      for (int unsigned b = 0; b < WIDTH; b++) begin
        unique case ({j[b], k[b]})
          JK_OP_HOLD:  r_q[b] <= r_q[b];
          JK_OP_CLEAR: r_q[b] <= 1'b0;
          JK_OP_SET:   r_q[b] <= 1'b1;
          default:     r_q[b] <= ~r_q[b];
        endcase
      end
    end
  end

  assign q    = r_q;
  assign qbar = ~r_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// ---------------------------------------------------------------------------
// jk_bank_arbiter
// Round-robin arbiter sharing one WIDTH-bit JK flip-flop bank between NREQ
// requesters. One command is accepted in IDLE, driven onto the bank in APPLY,
// and reported by a one-cycle done pulse when the result is visible on q.
//   clk, reset : clock, synchronous active-high reset
//   bus        : jk_bank_arbiter_if.slave (req_valid/op/mask in, req_ready out)
//   q, qbar    : bank state and its complement
//   done       : pulse, last accepted command now visible on q
//   done_id    : requester index of the completed command
// Optional feature macro: JK_ARB_LOCK_EN (adds bus.req_lock, requester lock).
// ---------------------------------------------------------------------------
module jk_bank_arbiter
  import jk_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                                       clk,
  input  logic                                       reset,
  jk_bank_arbiter_if.slave                           bus,
  output logic [WIDTH-1:0]                           q,
  output logic [WIDTH-1:0]                           qbar,
  output logic                                       done,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] done_id
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  jk_state_t        r_state;
  jk_state_t        w_next_state;

  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_mask;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   r_rr_ptr;
  logic             r_done;
  logic [IDW-1:0]   r_done_id;

  logic             w_pick_valid;
  logic [IDW-1:0]   w_pick;
  logic             w_accept;
  logic             w_apply;
  logic [NREQ-1:0]  w_ready;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_rr_frozen;

`ifdef JK_ARB_LOCK_EN
  logic             r_locked;
  logic [IDW-1:0]   r_lock_id;
  assign w_rr_frozen = r_locked;
`else
  assign w_rr_frozen = 1'b0;
`endif

  // Candidate selection: first valid requester scanning from rr_ptr+1.
  always_comb begin : arb
    int unsigned    cand;
    logic [IDW-1:0] cidx;
    w_pick_valid = 1'b0;
    w_pick       = '0;
    cand         = 0;
    cidx         = '0;
`ifdef JK_ARB_LOCK_EN
    if (r_locked) begin
      w_pick_valid = bus.req_valid[r_lock_id];
      w_pick       = r_lock_id;
    end else
`endif
    begin
      for (int unsigned off = 1; off <= NREQ; off++) begin
        cand = (32'(r_rr_ptr) + off) % NREQ;
        cidx = IDW'(cand);
        if (!w_pick_valid && bus.req_valid[cidx]) begin
          w_pick_valid = 1'b1;
          w_pick       = cidx;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state and outputs.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_apply      = 1'b0;
    w_ready      = '0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_accept     = 1'b1;
          w_ready      = NREQ'(1) << w_pick;
          w_next_state = APPLY;
        end
      end
      APPLY: begin
        w_apply      = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign bus.req_ready = w_ready;

  // J/K drive is nonzero only during APPLY, so the bank sees each command once.
  always_comb begin
    w_j = '0;
    w_k = '0;
    if (w_apply) begin
      for (int unsigned b = 0; b < WIDTH; b++) begin
        {w_j[b], w_k[b]} = jk_drive(r_op, r_mask[b]);
      end
    end
  end

  // Command register, round-robin pointer and done reporting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= JK_OP_HOLD;
      r_mask    <= '0;
      r_id      <= '0;
      r_rr_ptr  <= IDW'(NREQ - 1);
      r_done    <= 1'b0;
      r_done_id <= '0;
    end else begin
      r_done <= w_apply;
      if (w_apply) begin
        r_done_id <= r_id;
      end
      if (w_accept) begin
        r_op   <= bus.req_op[2*int'(w_pick) +: 2];
        r_mask <= bus.req_mask[WIDTH*int'(w_pick) +: WIDTH];
        r_id   <= w_pick;
        if (!w_rr_frozen) begin
          r_rr_ptr <= w_pick;
        end
      end
    end
  end

`ifdef JK_ARB_LOCK_EN
  // Lock follows the req_lock bit of each handshake; an idle cycle without
  // the owner's valid releases it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_locked  <= 1'b0;
      r_lock_id <= '0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_locked  <= bus.req_lock[w_pick];
        r_lock_id <= w_pick;
      end else if (r_locked && !bus.req_valid[r_lock_id]) begin
        r_locked <= 1'b0;
      end
    end
  end
`endif

  jk_reg_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .j     (w_j),
    .k     (w_k),
    .q     (q),
    .qbar  (qbar)
  );

  assign done    = r_done;
  assign done_id = r_done_id;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_jk_bank_arbiter
// Directed self-checking bench for jk_bank_arbiter (NREQ=4, WIDTH=8).
// Inputs change 1 time unit after the rising edge; outputs are checked
// shortly afterwards, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_jk_bank_arbiter;
  import jk_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             done;
  logic [1:0]       done_id;

  int n_cmp;
  int n_mis;

  jk_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  jk_bank_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .q       (q),
    .qbar    (qbar),
    .done    (done),
    .done_id (done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic v, input logic [1:0] op,
                         input logic [WIDTH-1:0] mask);
    bus.req_valid[idx]              = v;
    bus.req_op[2*idx +: 2]          = op;
    bus.req_mask[WIDTH*idx +: WIDTH] = mask;
  endtask

  task automatic clear_all();
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_mask  = '0;
`ifdef JK_ARB_LOCK_EN
    bus.req_lock  = '0;
`endif
  endtask

  task automatic pulse_reset();
    clear_all();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_all();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (q !== 8'h00) begin n_mis++; $display("FAIL reset_q got=%h exp=00", q); end
    n_cmp++; if (qbar !== 8'hFF) begin n_mis++; $display("FAIL reset_qbar got=%h exp=FF", qbar); end
    n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (done_id !== 2'd0) begin n_mis++; $display("FAIL reset_done_id got=%0d exp=0", done_id); end
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_mis++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
  endtask

  task automatic test_set();
    set_req(0, 1'b1, JK_OP_SET, 8'h0F);
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_mis++; $display("FAIL set_ready got=%b exp=0001", bus.req_ready); end
    tick();
    set_req(0, 1'b0, JK_OP_HOLD, 8'h00);
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_mis++; $display("FAIL set_apply_ready got=%b exp=0000", bus.req_ready); end
    n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL set_apply_done got=%b exp=0", done); end
    n_cmp++; if (q !== 8'h00) begin n_mis++; $display("FAIL set_apply_q got=%h exp=00", q); end
    tick();
    n_cmp++; if (q !== 8'h0F) begin n_mis++; $display("FAIL set_q got=%h exp=0F", q); end
    n_cmp++; if (qbar !== 8'hF0) begin n_mis++; $display("FAIL set_qbar got=%h exp=F0", qbar); end
    n_cmp++; if (done !== 1'b1) begin n_mis++; $display("FAIL set_done got=%b exp=1", done); end
    n_cmp++; if (done_id !== 2'd0) begin n_mis++; $display("FAIL set_done_id got=%0d exp=0", done_id); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL set_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ready;
    logic       exp_q0;
    pulse_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, JK_OP_TOGGLE, 8'h01);
    #1;
    exp_q0 = 1'b0;
    for (int g = 0; g < NREQ; g++) begin
      exp_ready = 4'b0001 << g;
      n_cmp++; if (bus.req_ready !== exp_ready) begin n_mis++; $display("FAIL rr_ready[%0d] got=%b exp=%b", g, bus.req_ready, exp_ready); end
      tick();
      set_req(g, 1'b0, JK_OP_HOLD, 8'h00);
      #1;
      n_cmp++; if (bus.req_ready !== 4'b0000) begin n_mis++; $display("FAIL rr_apply_ready[%0d] got=%b exp=0000", g, bus.req_ready); end
      tick();
      exp_q0 = ~exp_q0;
      n_cmp++; if (done !== 1'b1) begin n_mis++; $display("FAIL rr_done[%0d] got=%b exp=1", g, done); end
      n_cmp++; if (done_id !== 2'(g)) begin n_mis++; $display("FAIL rr_done_id[%0d] got=%0d exp=%0d", g, done_id, g); end
      n_cmp++; if (q[0] !== exp_q0) begin n_mis++; $display("FAIL rr_q0[%0d] got=%b exp=%b", g, q[0], exp_q0); end
    end
    n_cmp++; if (q !== 8'h00) begin n_mis++; $display("FAIL rr_final_q got=%h exp=00", q); end
  endtask

  task automatic test_clear_hold();
    set_req(2, 1'b1, JK_OP_SET, 8'hFF);
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_mis++; $display("FAIL ch_set_ready got=%b exp=0100", bus.req_ready); end
    tick();
    set_req(2, 1'b1, JK_OP_CLEAR, 8'hA5);
    tick();
    n_cmp++; if (q !== 8'hFF) begin n_mis++; $display("FAIL ch_set_q got=%h exp=FF", q); end
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_mis++; $display("FAIL ch_clr_ready got=%b exp=0100", bus.req_ready); end
    tick();
    set_req(2, 1'b1, JK_OP_HOLD, 8'hFF);
    tick();
    n_cmp++; if (q !== 8'h5A) begin n_mis++; $display("FAIL ch_clr_q got=%h exp=5A", q); end
    n_cmp++; if (qbar !== 8'hA5) begin n_mis++; $display("FAIL ch_clr_qbar got=%h exp=A5", qbar); end
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_mis++; $display("FAIL ch_hold_ready got=%b exp=0100", bus.req_ready); end
    tick();
    set_req(2, 1'b0, JK_OP_HOLD, 8'h00);
    tick();
    n_cmp++; if (q !== 8'h5A) begin n_mis++; $display("FAIL ch_hold_q got=%h exp=5A", q); end
    n_cmp++; if (done !== 1'b1) begin n_mis++; $display("FAIL ch_hold_done got=%b exp=1", done); end
    n_cmp++; if (done_id !== 2'd2) begin n_mis++; $display("FAIL ch_hold_done_id got=%0d exp=2", done_id); end
  endtask

  task automatic test_reset_in_apply();
    set_req(0, 1'b1, JK_OP_SET, 8'hFF);
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_mis++; $display("FAIL ra_ready got=%b exp=0001", bus.req_ready); end
    tick();
    set_req(0, 1'b0, JK_OP_HOLD, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (q !== 8'h00) begin n_mis++; $display("FAIL ra_q got=%h exp=00", q); end
    n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL ra_done got=%b exp=0", done); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL ra_no_done got=%b exp=0", done); end
    n_cmp++; if (q !== 8'h00) begin n_mis++; $display("FAIL ra_q_after got=%h exp=00", q); end
    set_req(0, 1'b1, JK_OP_SET, 8'h81);
    set_req(1, 1'b1, JK_OP_CLEAR, 8'h01);
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_mis++; $display("FAIL ra_first_ready got=%b exp=0001", bus.req_ready); end
    tick();
    set_req(0, 1'b0, JK_OP_HOLD, 8'h00);
    tick();
    n_cmp++; if (q !== 8'h81) begin n_mis++; $display("FAIL ra_r0_q got=%h exp=81", q); end
    n_cmp++; if (done_id !== 2'd0) begin n_mis++; $display("FAIL ra_r0_id got=%0d exp=0", done_id); end
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_mis++; $display("FAIL ra_r1_ready got=%b exp=0010", bus.req_ready); end
    tick();
    set_req(1, 1'b0, JK_OP_HOLD, 8'h00);
    tick();
    n_cmp++; if (q !== 8'h80) begin n_mis++; $display("FAIL ra_r1_q got=%h exp=80", q); end
    n_cmp++; if (done_id !== 2'd1) begin n_mis++; $display("FAIL ra_r1_id got=%0d exp=1", done_id); end
  endtask

`ifdef JK_ARB_LOCK_EN
  task automatic test_lock();
    pulse_reset();
    set_req(0, 1'b1, JK_OP_HOLD, 8'h00);
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_mis++; $display("FAIL lk_pre_ready got=%b exp=0001", bus.req_ready); end
    tick();
    set_req(1, 1'b1, JK_OP_TOGGLE, 8'h10);
    bus.req_lock[1] = 1'b1;
    tick();
    for (int n = 0; n < 4; n++) begin
      n_cmp++; if (bus.req_ready !== 4'b0010) begin n_mis++; $display("FAIL lk_ready[%0d] got=%b exp=0010", n, bus.req_ready); end
      tick();
      bus.req_lock[1] = (n < 2);
      tick();
      n_cmp++; if (done_id !== 2'd1) begin n_mis++; $display("FAIL lk_done_id[%0d] got=%0d exp=1", n, done_id); end
    end
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_mis++; $display("FAIL lk_release_ready got=%b exp=0001", bus.req_ready); end
    n_cmp++; if (q !== 8'h00) begin n_mis++; $display("FAIL lk_q got=%h exp=00", q); end
    clear_all();
    tick();
    tick();
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_mis = 0;
    reset = 1'b0;
    clear_all();
    test_reset();
    test_set();
    test_round_robin();
    test_clear_hold();
    test_reset_in_apply();
`ifdef JK_ARB_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
